// File: rtl/fp_product_accumulator.sv
// Sums a frame of up to N_TERMS unsigned 3Qp products into a full-width accumulator and
// returns the sum at full width and clamped to 3Qp, over valid/ready handshakes.
module fp_product_accumulator #(
  parameter int unsigned p       = 22,
  parameter int unsigned N_TERMS = 8,
  localparam int unsigned DW     = 3 + p,
  localparam int unsigned CNT_W  = $clog2(N_TERMS + 1),
  localparam int unsigned ACC_W  = DW + $clog2(N_TERMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_full,
  output logic [DW-1:0]    sum_sat,
  output logic             sat_flag,
  output logic [CNT_W-1:0] n_terms,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic [ACC_W-1:0]   in_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               done;
  logic               acc_sat;

  assign done    = (state_q == StDone);
  assign in_ready = ~done & ~rst;
  assign accept  = in_valid & in_ready;
  assign in_ext  = ACC_W'(in_data);
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            acc_q   <= in_ext;
            cnt_q   <= CNT_W'(1);
            state_q <= in_last ? StDone : StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            acc_q <= acc_q + in_ext;
            cnt_q <= cnt_inc;
            // The frame closes at N_TERMS whether or not in_last is present.
            if (in_last || (cnt_inc == CNT_W'(N_TERMS))) state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Results are gated by the state register so they read zero outside DONE.
  assign acc_sat   = |acc_q[ACC_W-1:DW];
  assign out_valid = done;
  assign sum_full  = done ? acc_q : '0;
  assign sat_flag  = done & acc_sat;
  assign sum_sat   = !done ? '0 : (acc_sat ? {DW{1'b1}} : acc_q[DW-1:0]);
  assign n_terms   = done ? cnt_q : '0;

endmodule
